spram32_ldr: RTL

Byte-stream bus initiator (master) on the 32-bit mb32_io memory bus. It fronts the 32K x 32 single-port RAM for the boot/console path.
- LOAD: writes a byte stream (e.g. from the UART receiver) into RAM using per-byte write masks.
- DUMP: reads RAM words back and streams them out as bytes.
Byte lanes are little-endian: lane 0 = bits 7:0.

---
 rtl/mb32_pkg.sv | 24 ++
 rtl/mb32_io.sv | 18 +
 rtl/spram32_32k.sv | 26 ++
 rtl/spram32_bsel.sv | 10 +
 rtl/spram32_ldr.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mb32_pkg.sv
// Shared definitions for the mb32_io memory bus and the byte-stream loader.
// Holds bus geometry, loader state encoding, command opcodes and the lane-mask helper.
package mb32_pkg;

    localparam int ASZ = 15;
    localparam int BSZ = ASZ + 2;

    localparam logic LDR_OP_LOAD = 1'b0;
    localparam logic LDR_OP_DUMP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DREQ,
        DLAT,
        DSEND
    } ldr_state_e;

    // One-hot write mask selecting the little-endian byte lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mb32_io.sv
// 32-bit single-port memory bus: word address, write data, byte write mask, read data.
// The clock is shared by master and slave and enters as an interface port.
interface mb32_io
    import mb32_pkg::*;
(
    input logic clk
);

    logic [ASZ-1:0] ai;
    logic [31:0]    vi;
    logic           we;
    logic [3:0]     bmsk;
    logic [31:0]    vo;

    modport master (input clk, output ai, output vi, output we, output bmsk, input vo);
    modport slave  (input clk, input ai, input vi, input we, input bmsk, output vo);

endinterface

// File: rtl/spram32_32k.sv
// 32K x 32 single-port RAM with per-byte write enables and one-cycle read latency.
// Address and write data are sampled at the clock edge; vo is valid the following cycle.
module spram32_32k
    import mb32_pkg::*;
(
    mb32_io.slave b32_if
);

    logic [31:0] mem [0:(1 << ASZ) - 1];
    logic [31:0] vo_q;

    // NOTE: the storage array has no reset; clearing 32K words is neither needed nor cheap in a RAM macro.
    always_ff @(posedge b32_if.clk) begin
        if (b32_if.we) begin
            for (int i = 0; i < 4; i++) begin
                if (b32_if.bmsk[i]) begin
                    mem[b32_if.ai][8*i +: 8] <= b32_if.vi[8*i +: 8];
                end
            end
        end
        vo_q <= mem[b32_if.ai];
    end

    assign b32_if.vo = vo_q;

endmodule

// File: rtl/spram32_bsel.sv
// Combinational little-endian byte-lane extractor: lane 0 is bits 7:0.
module spram32_bsel (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    output logic [7:0]  byte_o
);

    assign byte_o = word_i[8*lane_i +: 8];

endmodule

// File: rtl/spram32_ldr.sv
// Byte-stream initiator on mb32_io: LOAD writes an rx byte stream with byte masks,
// DUMP reads words back and streams them out byte by byte on tx.
module spram32_ldr
    import mb32_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_rdy,
    input  logic           cmd_op,
    input  logic [BSZ-1:0] cmd_addr,
    input  logic [BSZ-1:0] cmd_len,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_rdy,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_rdy,
    output logic           busy,
    output logic           done,
    mb32_io.master         b32_if
);

    ldr_state_e     state_q, state_d;
    logic [BSZ-1:0] addr_q, addr_d;
    logic [BSZ-1:0] len_q, len_d;
    logic [31:0]    word_q, word_d;
    logic [ASZ-1:0] ai_q, ai_d;
    logic [31:0]    vi_q, vi_d;
    logic           we_q, we_d;
    logic [3:0]     bmsk_q, bmsk_d;
    logic           done_q, done_d;

    logic [BSZ-1:0] addr_inc;
    logic [7:0]     lane_byte;
    logic           cmd_fire;
    logic           rx_fire;
    logic           tx_fire;

    assign addr_inc = addr_q + BSZ'(1);
    assign cmd_fire = cmd_valid & cmd_rdy;
    assign rx_fire  = rx_valid & rx_rdy;
    assign tx_fire  = tx_valid & tx_rdy;

    spram32_bsel u_bsel (
        .word_i (word_q),
        .lane_i (addr_q[1:0]),
        .byte_o (lane_byte)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            word_q  <= '0;
            ai_q    <= '0;
            vi_q    <= '0;
            we_q    <= 1'b0;
            bmsk_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            word_q  <= word_d;
            ai_q    <= ai_d;
            vi_q    <= vi_d;
            we_q    <= we_d;
            bmsk_q  <= bmsk_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        word_d  = word_q;
        ai_d    = ai_q;
        vi_d    = vi_q;
        we_d    = 1'b0;
        bmsk_d  = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_op == LDR_OP_LOAD) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DREQ;
                        ai_d    = cmd_addr[BSZ-1:2];
                    end
                end
            end
            LOAD: begin
                // The cycle with len already at zero is the final write cycle.
                if (len_q == '0) begin
                    state_d = IDLE;
                end
                if (rx_fire) begin
                    ai_d   = addr_q[BSZ-1:2];
                    vi_d   = {4{rx_data}};
                    bmsk_d = lane_mask(addr_q[1:0]);
                    we_d   = 1'b1;
                    addr_d = addr_inc;
                    len_d  = len_q - BSZ'(1);
                    done_d = (len_q == BSZ'(1));
                end
            end
            DREQ: begin
                state_d = DLAT;
            end
            DLAT: begin
                word_d  = b32_if.vo;
                state_d = DSEND;
            end
            DSEND: begin
                if (tx_fire) begin
                    addr_d = addr_inc;
                    len_d  = len_q - BSZ'(1);
                    if (len_q == BSZ'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (addr_inc[1:0] == 2'b00) begin
                        state_d = DREQ;
                        ai_d    = addr_inc[BSZ-1:2];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_rdy  = (state_q == IDLE);
        rx_rdy   = (state_q == LOAD) && (len_q != '0);
        tx_valid = (state_q == DSEND);
        tx_data  = (state_q == DSEND) ? lane_byte : 8'h00;
        busy     = (state_q != IDLE);
        done     = done_q;
    end

    assign b32_if.ai   = ai_q;
    assign b32_if.vi   = vi_q;
    assign b32_if.we   = we_q;
    assign b32_if.bmsk = bmsk_q;

endmodule
